// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 64:1 select mux: walks ctrl0..ctrl5 through every channel, samples
// mux_out after a settle delay and delivers the 64-bit snapshot with valid/ack.
// Optional parity output of each snapshot is enabled with `define MUX_SCAN_PARITY_EN.
module mux_scan_seq #(
    parameter int SETTLE = 2,
    parameter int NUM_CH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ctrl0,
    output logic              ctrl1,
    output logic              ctrl2,
    output logic              ctrl3,
    output logic              ctrl4,
    output logic              ctrl5,
    input  logic              mux_out,
    output logic [NUM_CH-1:0] data,
    output logic              valid,
    input  logic              ack,
`ifdef MUX_SCAN_PARITY_EN
    output logic              parity,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);
    localparam logic [5:0] LAST_IDX = 6'(NUM_CH - 1);

    state_t              r_state;
    state_t              w_next;
    logic [5:0]          r_idx;
    logic [3:0]          r_cnt;
    logic [NUM_CH-1:0]   r_cap;
    logic [NUM_CH-1:0]   r_data;
    logic                r_valid;
    logic [NUM_CH-1:0]   w_capNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == LAST_CNT) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_idx == LAST_IDX) ? S_DONE : S_SETTLE;
            S_DONE:   if (ack) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Snapshot including the sample being taken this cycle, so DONE entry sees the last channel.
    always_comb begin
        w_capNext        = r_cap;
        w_capNext[r_idx] = mux_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    r_cap <= w_capNext;
                    r_cnt <= '0;
                    if (r_idx == LAST_IDX) begin
                        r_data  <= w_capNext;
                        r_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (r_state == S_SAMPLE && r_idx == LAST_IDX) begin
            r_parity <= ^w_capNext;
        end
    end

    assign parity = r_parity;
`endif

    assign {ctrl0, ctrl1, ctrl2, ctrl3, ctrl4, ctrl5} = r_idx;
    assign data  = r_data;
    assign valid = r_valid;
    assign busy  = (r_state != S_IDLE);

endmodule
